// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch control ahead of the instruction memory.
// Selects the next PC, traps misaligned/out-of-range targets, halts on a self-jump and counts retired fetches.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC          = 32'h0000_0000,
    parameter int          MEM_WORDS         = 32,
    parameter bit          HALT_ON_SELF_JUMP = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_offset_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        jump_reg_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] pc_out_o,
    output logic [31:0] pc_plus4_o,
    output logic        fetch_valid_o,
    output logic        halted_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o,
    output logic [31:0] retired_cnt_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] fault_pc_q;
    logic [31:0] retired_q;
    logic [31:0] retired_d;
    logic        fetch_valid_q;
    logic        halted_q;
    logic        fault_q;

    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;
    logic        redirect_s;
    logic        misaligned_s;
    logic        out_of_range_s;
    logic        self_jump_s;

    assign pc_plus4_s = pc_q + 32'd4;

    // Next-PC selection: jump_reg beats jump beats branch beats sequential.
    always_comb begin
        target_s   = pc_plus4_s;
        redirect_s = 1'b0;
        if (jump_reg_i) begin
            target_s   = jr_target_i;
            redirect_s = 1'b1;
        end else if (jump_i) begin
            target_s   = {pc_plus4_s[31:28], jump_index_i, 2'b00};
            redirect_s = 1'b1;
        end else if (branch_taken_i) begin
            target_s   = pc_plus4_s + {branch_offset_i[29:0], 2'b00};
            redirect_s = 1'b1;
        end else begin
            target_s   = pc_plus4_s;
            redirect_s = 1'b0;
        end
    end

    // Target checks and saturating retire count.
    always_comb begin
        misaligned_s   = (target_s[1:0] != 2'b00);
        out_of_range_s = ({2'b00, target_s[31:2]} >= MEM_WORDS_W);
        self_jump_s    = HALT_ON_SELF_JUMP && redirect_s && (target_s == pc_q);
        if (retired_q == 32'hFFFF_FFFF) begin
            retired_d = retired_q;
        end else begin
            retired_d = retired_q + 32'd1;
        end
    end

    // Fetch FSM; HALT and FAULT are only left through reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            fault_pc_q    <= 32'h0000_0000;
            retired_q     <= 32'h0000_0000;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q       <= ST_RUN;
                    fetch_valid_q <= 1'b1;
                end
                ST_RUN: begin
                    if (!stall_i) begin
                        retired_q <= retired_d;
                        if (misaligned_s || out_of_range_s) begin
                            state_q       <= ST_FAULT;
                            fault_pc_q    <= target_s;
                            fault_q       <= 1'b1;
                            fetch_valid_q <= 1'b0;
                        end else if (self_jump_s) begin
                            state_q       <= ST_HALT;
                            halted_q      <= 1'b1;
                            fetch_valid_q <= 1'b0;
                        end else begin
                            pc_q <= target_s;
                        end
                    end
                end
                ST_HALT, ST_FAULT: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q       <= ST_FAULT;
                    fault_q       <= 1'b1;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out_o      = pc_q;
    assign pc_plus4_o    = pc_plus4_s;
    assign fetch_valid_o = fetch_valid_q;
    assign halted_o      = halted_q;
    assign fault_o       = fault_q;
    assign fault_pc_o    = fault_pc_q;
    assign retired_cnt_o = retired_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: the driver queues hand-computed expectations,
// the monitor pops one per clock (or on async reset) and compares.
module tb_pc_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_offset_i = 32'h0;
    logic        jump_i = 1'b0;
    logic [25:0] jump_index_i = 26'h0;
    logic        jump_reg_i = 1'b0;
    logic [31:0] jr_target_i = 32'h0;
    logic [31:0] pc_out_o;
    logic [31:0] pc_plus4_o;
    logic        fetch_valid_o;
    logic        halted_o;
    logic        fault_o;
    logic [31:0] fault_pc_o;
    logic [31:0] retired_cnt_o;

    pc_fetch_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_offset_i(branch_offset_i),
        .jump_i(jump_i), .jump_index_i(jump_index_i),
        .jump_reg_i(jump_reg_i), .jr_target_i(jr_target_i),
        .pc_out_o(pc_out_o), .pc_plus4_o(pc_plus4_o),
        .fetch_valid_o(fetch_valid_o), .halted_o(halted_o), .fault_o(fault_o),
        .fault_pc_o(fault_pc_o), .retired_cnt_o(retired_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        fv;
        logic        h;
        logic        f;
        logic [31:0] fpc;
        logic [31:0] ret;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
            n_miss++;
        end
    endtask

    // Monitor: compare after every clock edge or async reset assertion when an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i or posedge rst_i);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_vec++;
                chk(e.name, "pc_out",      pc_out_o,              e.pc);
                chk(e.name, "pc_plus4",    pc_plus4_o,            e.pc + 32'd4);
                chk(e.name, "fetch_valid", {31'd0, fetch_valid_o}, {31'd0, e.fv});
                chk(e.name, "halted",      {31'd0, halted_o},      {31'd0, e.h});
                chk(e.name, "fault",       {31'd0, fault_o},       {31'd0, e.f});
                chk(e.name, "fault_pc",    fault_pc_o,            e.fpc);
                chk(e.name, "retired_cnt", retired_cnt_o,         e.ret);
            end
        end
    end

    task automatic vec(input string nm, input logic st, input logic br, input logic [31:0] off,
                       input logic j, input logic [25:0] ji, input logic jr, input logic [31:0] jt,
                       input logic [31:0] e_pc, input logic e_fv, input logic e_h, input logic e_f,
                       input logic [31:0] e_fpc, input logic [31:0] e_ret);
        stall_i = st; branch_taken_i = br; branch_offset_i = off;
        jump_i = j; jump_index_i = ji; jump_reg_i = jr; jr_target_i = jt;
        q.push_back('{nm, e_pc, e_fv, e_h, e_f, e_fpc, e_ret});
        @(negedge clk_i);
    endtask

    task automatic idle(input string nm, input logic [31:0] e_pc, input logic e_fv, input logic e_h,
                        input logic e_f, input logic [31:0] e_fpc, input logic [31:0] e_ret);
        vec(nm, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, e_pc, e_fv, e_h, e_f, e_fpc, e_ret);
    endtask

    // Called at a negedge; asserts rst mid-cycle and checks reset values before the next clock edge.
    task automatic do_reset(input string nm);
        #2;
        stall_i = 1'b0; branch_taken_i = 1'b0; branch_offset_i = 32'h0;
        jump_i = 1'b0; jump_index_i = 26'h0; jump_reg_i = 1'b0; jr_target_i = 32'h0;
        q.push_back('{nm, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        @(negedge clk_i);
        // 1: boot and sequential fetch
        do_reset("reset0");
        idle("boot",  32'h00, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
        idle("seq1",  32'h04, 1'b1, 1'b0, 1'b0, 32'h0, 32'd1);
        idle("seq2",  32'h08, 1'b1, 1'b0, 1'b0, 32'h0, 32'd2);
        idle("seq3",  32'h0C, 1'b1, 1'b0, 1'b0, 32'h0, 32'd3);
        idle("seq4",  32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 32'd4);
        // 2: backward branch, then jump beating branch
        vec("br_back", 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0, 1'b0, 32'h0,
            32'h0C, 1'b1, 1'b0, 1'b0, 32'h0, 32'd5);
        idle("seq5",  32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 32'd6);
        vec("j_over_br", 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 26'd5, 1'b0, 32'h0,
            32'h14, 1'b1, 1'b0, 1'b0, 32'h0, 32'd7);
        // 3: stall beats jr
        for (int i = 0; i < 3; i++)
            vec("stall_jr", 1'b1, 1'b0, 32'h0, 1'b0, 26'd0, 1'b1, 32'h40,
                32'h14, 1'b1, 1'b0, 1'b0, 32'h0, 32'd7);
        vec("jr_go", 1'b0, 1'b0, 32'h0, 1'b0, 26'd0, 1'b1, 32'h40,
            32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 32'd8);
        vec("jr_prio", 1'b0, 1'b1, 32'h1, 1'b1, 26'd3, 1'b1, 32'h08,
            32'h08, 1'b1, 1'b0, 1'b0, 32'h0, 32'd9);
        // 4: misaligned jr faults, fault is terminal
        vec("jr_misal", 1'b0, 1'b0, 32'h0, 1'b0, 26'd0, 1'b1, 32'h22,
            32'h08, 1'b0, 1'b0, 1'b1, 32'h22, 32'd10);
        vec("fault_hold1", 1'b0, 1'b1, 32'h1, 1'b1, 26'd1, 1'b1, 32'h10,
            32'h08, 1'b0, 1'b0, 1'b1, 32'h22, 32'd10);
        idle("fault_hold2", 32'h08, 1'b0, 1'b0, 1'b1, 32'h22, 32'd10);
        // 4b: sequential fall-off-end faults
        do_reset("reset1");
        idle("boot1", 32'h00, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
        vec("j_last", 1'b0, 1'b0, 32'h0, 1'b1, 26'd31, 1'b0, 32'h0,
            32'h7C, 1'b1, 1'b0, 1'b0, 32'h0, 32'd1);
        idle("fall_off", 32'h7C, 1'b0, 1'b0, 1'b1, 32'h80, 32'd2);
        // 5: self-jump halts, inputs ignored afterwards
        do_reset("reset2");
        idle("boot2", 32'h00, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
        vec("j_24", 1'b0, 1'b0, 32'h0, 1'b1, 26'd9, 1'b0, 32'h0,
            32'h24, 1'b1, 1'b0, 1'b0, 32'h0, 32'd1);
        vec("self_j", 1'b0, 1'b0, 32'h0, 1'b1, 26'd9, 1'b0, 32'h0,
            32'h24, 1'b0, 1'b1, 1'b0, 32'h0, 32'd2);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] iv;
            iv = 32'(i);
            vec("halt_hold", iv[0], ~iv[0], iv, 1'b1, iv[25:0], iv[1], 32'h40,
                32'h24, 1'b0, 1'b1, 1'b0, 32'h0, 32'd2);
        end
        // 6: async reset mid-run at 0x18
        do_reset("reset3");
        idle("boot3", 32'h00, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
        vec("j_18", 1'b0, 1'b0, 32'h0, 1'b1, 26'd6, 1'b0, 32'h0,
            32'h18, 1'b1, 1'b0, 1'b0, 32'h0, 32'd1);
        do_reset("async_rst");
        // 6b: retire counter saturation
        idle("boot4", 32'h00, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
        force dut.retired_q = 32'hFFFF_FFFE;
        #1;
        release dut.retired_q;
        idle("sat1", 32'h04, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
        idle("sat2", 32'h08, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
        idle("sat3", 32'h0C, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);
        vec("br_fwd", 1'b0, 1'b1, 32'h3, 1'b0, 26'd0, 1'b0, 32'h0,
            32'h1C, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF);

        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk_i);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations pending, expected 0", q.size());
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
